seq_round_judge: RTL and testbench

- Scoring and decision stage of the two-player timed sequence-matching game.
- Sits directly downstream of the RNG target generator and the player input capture (PA/PB with AcsPA/AcsPB strobes).
- Runs a fixed number of timed rounds and scores each player's guess against the target digit.
- Produces per-player scores and the final WinA/WinB/Tie decision consumed by the seven-segment display stage.

---
 rtl/seq_round_judge_if.sv | 26 ++
 rtl/seq_round_judge.sv | 148 ++++++++++++++
 tb/tb_seq_round_judge.sv | 361 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/seq_round_judge_if.sv
// seq_round_judge_if: game-control, target, guess and score/decision signals
// between the upstream RNG/input capture, the round judge and the display stage.
//   master : drives Start/Stop, RngVal/RngVld, PAVal/PAVld, PBVal/PBVld;
//            observes scores, Round, TimeLeft, RoundDone, Busy, WinA/WinB/Tie
//   slave  : the judge (mirror of master)
interface seq_round_judge_if #(parameter int TW = 8);
  logic          Start, Stop;
  logic [3:0]    RngVal;
  logic          RngVld;
  logic [3:0]    PAVal;
  logic          PAVld;
  logic [3:0]    PBVal;
  logic          PBVld;
  logic [3:0]    ScoreA, ScoreB, Round;
  logic [TW-1:0] TimeLeft;
  logic          RoundDone, Busy, WinA, WinB, Tie;

  modport master (
    output Start, Stop, RngVal, RngVld, PAVal, PAVld, PBVal, PBVld,
    input  ScoreA, ScoreB, Round, TimeLeft, RoundDone, Busy, WinA, WinB, Tie
  );
  modport slave (
    input  Start, Stop, RngVal, RngVld, PAVal, PAVld, PBVal, PBVld,
    output ScoreA, ScoreB, Round, TimeLeft, RoundDone, Busy, WinA, WinB, Tie
  );
endinterface

// File: rtl/seq_round_judge.sv
// seq_round_judge: scoring/decision stage of the two-player timed
// sequence-matching game. Runs ROUNDS timed rounds, scores each player's
// first guess per round against the latched target digit and produces the
// final WinA/WinB/Tie decision.
// Ports:
//   Clk  - rising-edge clock
//   Rst  - synchronous active-low reset
//   bus  - seq_round_judge_if.slave (game control, target, guesses, results)
// Build option: FIRST_BONUS_EN - first correct guess of a round earns +2,
//   a later correct guess by the other player +1 (default: every hit +1).
module seq_round_judge #(
  parameter int ROUNDS  = 4,
  parameter int TIMEOUT = 50,
  parameter int TW      = 8
) (
  input  logic Clk,
  input  logic Rst,
  seq_round_judge_if.slave bus
);

  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_GUESS, S_SETTLE, S_OVER} state_t;

  localparam logic [4:0] ROUNDS_W = 5'(ROUNDS);

  state_t        state_q;
  logic [3:0]    score_a_q, score_b_q, round_q, target_q;
  logic [TW-1:0] tl_q;
  logic          lock_a_q, lock_b_q, first_q;
  logic          done_q, win_a_q, win_b_q, tie_q;

  logic          take_a, take_b, hit_a, hit_b;
  logic          lock_a_d, lock_b_d, busy, last_round, go_over;
  logic [3:0]    inc_a, inc_b, score_a_d, score_b_d;
  logic [TW-1:0] tl_dec;

  function automatic logic [3:0] sat_add(input logic [3:0] a, input logic [3:0] b);
    logic [4:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[4] ? 4'hF : s[3:0];
  endfunction

  always_comb begin
    take_a    = bus.PAVld & ~lock_a_q;
    take_b    = bus.PBVld & ~lock_b_q;
    hit_a     = take_a & (bus.PAVal == target_q);
    hit_b     = take_b & (bus.PBVal == target_q);
    lock_a_d  = lock_a_q | take_a;
    lock_b_d  = lock_b_q | take_b;
    tl_dec    = tl_q - 1'b1;
`ifdef FIRST_BONUS_EN
    // Simultaneous first hits both count as "first".
    inc_a     = hit_a ? (first_q ? 4'd1 : 4'd2) : 4'd0;
    inc_b     = hit_b ? (first_q ? 4'd1 : 4'd2) : 4'd0;
`else
    inc_a     = {3'b000, hit_a};
    inc_b     = {3'b000, hit_b};
`endif
    score_a_d = sat_add(score_a_q, inc_a);
    score_b_d = sat_add(score_b_q, inc_b);
  end

  assign busy       = (state_q == S_WAIT) || (state_q == S_GUESS) || (state_q == S_SETTLE);
  assign last_round = ({1'b0, round_q} + 5'd1) == ROUNDS_W;
  // Stop beats everything else, including the SETTLE bookkeeping.
  assign go_over    = (busy && bus.Stop) || (state_q == S_SETTLE && last_round);

  always_ff @(posedge Clk) begin
    if (!Rst) begin
      state_q   <= S_IDLE;
      score_a_q <= '0;
      score_b_q <= '0;
      round_q   <= '0;
      target_q  <= '0;
      tl_q      <= '0;
      lock_a_q  <= 1'b0;
      lock_b_q  <= 1'b0;
      first_q   <= 1'b0;
      done_q    <= 1'b0;
      win_a_q   <= 1'b0;
      win_b_q   <= 1'b0;
      tie_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: if (bus.Start) begin
          score_a_q <= '0;
          score_b_q <= '0;
          round_q   <= '0;
          state_q   <= S_WAIT;
        end
        S_WAIT: if (!bus.Stop && bus.RngVld) begin
          target_q <= bus.RngVal;
          tl_q     <= TW'(TIMEOUT);
          lock_a_q <= 1'b0;
          lock_b_q <= 1'b0;
          first_q  <= 1'b0;
          state_q  <= S_GUESS;
        end
        S_GUESS: if (!bus.Stop) begin
          score_a_q <= score_a_d;
          score_b_q <= score_b_d;
          lock_a_q  <= lock_a_d;
          lock_b_q  <= lock_b_d;
          first_q   <= first_q | hit_a | hit_b;
          // TimeLeft is forced to 0 on exit so it reads 0 outside GUESS.
          if ((lock_a_d && lock_b_d) || tl_dec == '0) begin
            tl_q    <= '0;
            state_q <= S_SETTLE;
          end else begin
            tl_q <= tl_dec;
          end
        end
        S_SETTLE: if (!bus.Stop) begin
          done_q  <= 1'b1;
          round_q <= round_q + 4'd1;
          state_q <= S_WAIT;
        end
        S_OVER: if (!bus.Start) begin
          win_a_q <= 1'b0;
          win_b_q <= 1'b0;
          tie_q   <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
      // Scores cannot change on the edge that enters GAME_OVER, so the
      // decision is taken from the current score registers.
      if (go_over) begin
        state_q <= S_OVER;
        tl_q    <= '0;
        win_a_q <= score_a_q > score_b_q;
        win_b_q <= score_b_q > score_a_q;
        tie_q   <= score_a_q == score_b_q;
      end
    end
  end

  assign bus.ScoreA    = score_a_q;
  assign bus.ScoreB    = score_b_q;
  assign bus.Round     = round_q;
  assign bus.TimeLeft  = tl_q;
  assign bus.RoundDone = done_q;
  assign bus.Busy      = busy;
  assign bus.WinA      = win_a_q;
  assign bus.WinB      = win_b_q;
  assign bus.Tie       = tie_q;

endmodule

// File: tb/tb_seq_round_judge.sv
// tb_seq_round_judge: scoreboard bench for seq_round_judge (ROUNDS=4,
// TIMEOUT=50, TW=8). Expected per-round scores/Round are pushed when a
// round's stimulus is driven and popped when RoundDone pulses.
module tb_seq_round_judge;

  logic Clk, Rst;
  seq_round_judge_if #(.TW(8)) bus();

  seq_round_judge #(.ROUNDS(4), .TIMEOUT(50), .TW(8)) dut (
    .Clk(Clk), .Rst(Rst), .bus(bus.slave)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct { logic [3:0] a, b, r; } exp_t;
  exp_t sbq[$];

  int  n_chk, n_fail;
  int  mA, mB, mR;
  bit  mfirst;

  task automatic tick;
    @(posedge Clk);
    #1;
  endtask

  function automatic void mdl_hits(input bit ha, input bit hb);
    int inc;
`ifdef FIRST_BONUS_EN
    inc = mfirst ? 1 : 2;
`else
    inc = 1;
`endif
    if (ha) mA = (mA + inc > 15) ? 15 : mA + inc;
    if (hb) mB = (mB + inc > 15) ? 15 : mB + inc;
    if (ha || hb) mfirst = 1'b1;
  endfunction

  task automatic mdl_reset;
    mA = 0; mB = 0; mR = 0; mfirst = 1'b0;
  endtask

  // Drives one round from WAIT_TGT: target strobe, then each player's guess
  // at its lag (cycles after GUESS entry). Pushes the expected end-of-round
  // result.
  task automatic run_round(input logic [3:0] tgt, input bit a_en, input logic [3:0] av,
                           input int al, input bit b_en, input logic [3:0] bv, input int bl);
    exp_t e;
    bit   ha, hb;
    int   last;
    ha = a_en && (av == tgt);
    hb = b_en && (bv == tgt);
    mfirst = 1'b0;
    if (!a_en || !b_en || al == bl) mdl_hits(ha, hb);
    else if (al < bl) begin mdl_hits(ha, 1'b0); mdl_hits(1'b0, hb); end
    else begin mdl_hits(1'b0, hb); mdl_hits(ha, 1'b0); end
    mR++;
    e.a = mA[3:0]; e.b = mB[3:0]; e.r = mR[3:0];
    sbq.push_back(e);
    bus.RngVal = tgt; bus.RngVld = 1'b1;
    tick;
    bus.RngVld = 1'b0;
    last = (al > bl) ? al : bl;
    for (int c = 0; c <= last; c++) begin
      bus.PAVld = a_en && (c == al); bus.PAVal = av;
      bus.PBVld = b_en && (c == bl); bus.PBVal = bv;
      tick;
    end
    bus.PAVld = 1'b0; bus.PBVld = 1'b0;
  endtask

  task automatic wait_done(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 80; i++) begin
      if (bus.RoundDone === 1'b1) begin ok = 1'b1; break; end
      tick;
    end
  endtask

  task automatic test_power_on;
    Rst = 1'b0;
    bus.Start = 0; bus.Stop = 0; bus.RngVal = 0; bus.RngVld = 0;
    bus.PAVal = 0; bus.PAVld = 0; bus.PBVal = 0; bus.PBVld = 0;
    tick; tick;
    Rst = 1'b1;
    n_chk++;
    if ({bus.ScoreA, bus.ScoreB, bus.Round, bus.TimeLeft, bus.RoundDone, bus.Busy,
         bus.WinA, bus.WinB, bus.Tie} !== 25'd0) begin
      n_fail++;
      $display("FAIL power_on outputs: got %h want 0", {bus.ScoreA, bus.ScoreB, bus.Round,
               bus.TimeLeft, bus.RoundDone, bus.Busy, bus.WinA, bus.WinB, bus.Tie});
    end
  endtask

  task automatic test_basic;
    exp_t e;
    mdl_reset;
    bus.Start = 1'b1;
    tick;
    n_chk++;
    if (bus.Busy !== 1'b1) begin n_fail++; $display("FAIL basic busy: got %b want 1", bus.Busy); end
    bus.RngVal = 4'b1010; bus.RngVld = 1'b1;
    tick;
    bus.RngVld = 1'b0;
    n_chk++;
    if (bus.TimeLeft !== 8'd50) begin n_fail++; $display("FAIL basic tl_load: got %0d want 50", bus.TimeLeft); end
    bus.PAVal = 4'b1010; bus.PAVld = 1'b1; bus.PBVal = 4'b1100; bus.PBVld = 1'b1;
    mfirst = 1'b0; mdl_hits(1'b1, 1'b0); mR = 1;
    e.a = mA[3:0]; e.b = mB[3:0]; e.r = 4'd1; sbq.push_back(e);
    tick;
    bus.PAVld = 1'b0; bus.PBVld = 1'b0;
    n_chk++;
    if ({bus.ScoreA, bus.ScoreB, bus.RoundDone} !== {e.a, e.b, 1'b0}) begin
      n_fail++; $display("FAIL basic score_settle: got %h want %h", {bus.ScoreA, bus.ScoreB, bus.RoundDone}, {e.a, e.b, 1'b0});
    end
    tick;
    e = sbq.pop_front();
    n_chk++;
    if ({bus.RoundDone, bus.ScoreA, bus.ScoreB, bus.Round} !== {1'b1, e.a, e.b, e.r}) begin
      n_fail++; $display("FAIL basic round_done: got %h want %h", {bus.RoundDone, bus.ScoreA, bus.ScoreB, bus.Round}, {1'b1, e.a, e.b, e.r});
    end
    tick;
    n_chk++;
    if (bus.RoundDone !== 1'b0) begin n_fail++; $display("FAIL basic pulse_width: got %b want 0", bus.RoundDone); end
  endtask

  task automatic test_timeout;
    exp_t e;
    int   k;
    bit   tl_ok;
    bus.RngVal = 4'b1110; bus.RngVld = 1'b1;
    tick;
    bus.RngVld = 1'b0;
    mfirst = 1'b0; mR = 2;
    e.a = mA[3:0]; e.b = mB[3:0]; e.r = 4'd2; sbq.push_back(e);
    bus.PBVal = 4'b1000; bus.PBVld = 1'b1;
    k = 0; tl_ok = 1'b1;
    while (bus.RoundDone !== 1'b1 && k < 80) begin
      if (bus.TimeLeft !== ((k <= 50) ? 8'(50 - k) : 8'd0)) tl_ok = 1'b0;
      tick;
      bus.PBVld = 1'b0;
      k++;
    end
    n_chk++;
    if (k != 51) begin n_fail++; $display("FAIL timeout latency: got %0d want 51", k); end
    n_chk++;
    if (!tl_ok) begin n_fail++; $display("FAIL timeout tl_count: got mismatch want 50..0"); end
    e = sbq.pop_front();
    n_chk++;
    if ({bus.ScoreA, bus.ScoreB, bus.Round} !== {e.a, e.b, e.r}) begin
      n_fail++; $display("FAIL timeout score: got %h want %h", {bus.ScoreA, bus.ScoreB, bus.Round}, {e.a, e.b, e.r});
    end
  endtask

  task automatic test_duplicate;
    exp_t e;
    bit   ok;
    bus.RngVal = 4'd3; bus.RngVld = 1'b1;
    tick;
    bus.RngVld = 1'b0;
    mfirst = 1'b0; mdl_hits(1'b0, 1'b1); mR = 3;
    e.a = mA[3:0]; e.b = mB[3:0]; e.r = 4'd3; sbq.push_back(e);
    bus.PAVal = 4'd5; bus.PAVld = 1'b1;
    tick;
    bus.PAVal = 4'd3;
    tick;
    bus.PAVld = 1'b0; bus.PBVal = 4'd3; bus.PBVld = 1'b1;
    tick;
    bus.PBVld = 1'b0;
    wait_done(ok);
    n_chk++;
    if (!ok) begin n_fail++; $display("FAIL dup round_done: got none want pulse"); end
    e = sbq.pop_front();
    n_chk++;
    if ({bus.ScoreA, bus.ScoreB, bus.Round} !== {e.a, e.b, e.r}) begin
      n_fail++; $display("FAIL dup score: got %h want %h", {bus.ScoreA, bus.ScoreB, bus.Round}, {e.a, e.b, e.r});
    end
  endtask

  task automatic test_last_cycle;
    exp_t e;
    bit   ok, seen;
    bus.RngVal = 4'd7; bus.RngVld = 1'b1;
    tick;
    bus.RngVld = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (bus.TimeLeft === 8'd1) begin seen = 1'b1; break; end
      tick;
    end
    n_chk++;
    if (!seen) begin n_fail++; $display("FAIL last tl_one: got %0d want 1", bus.TimeLeft); end
    mfirst = 1'b0; mdl_hits(1'b1, 1'b0); mR = 4;
    e.a = mA[3:0]; e.b = mB[3:0]; e.r = 4'd4; sbq.push_back(e);
    bus.PAVal = 4'd7; bus.PAVld = 1'b1;
    tick;
    bus.PAVld = 1'b0;
    wait_done(ok);
    e = sbq.pop_front();
    n_chk++;
    if (!ok || {bus.ScoreA, bus.ScoreB, bus.Round} !== {e.a, e.b, e.r}) begin
      n_fail++; $display("FAIL last score: got %h want %h", {bus.ScoreA, bus.ScoreB, bus.Round}, {e.a, e.b, e.r});
    end
    tick; tick;
    n_chk++;
    if ({bus.WinA, bus.WinB, bus.Tie, bus.Busy, bus.TimeLeft} !== {mA > mB, mB > mA, mA == mB, 1'b0, 8'd0}) begin
      n_fail++; $display("FAIL last game_over: got %b%b%b busy %b want %b%b%b busy 0", bus.WinA, bus.WinB, bus.Tie, bus.Busy, mA > mB, mB > mA, mA == mB);
    end
    bus.Start = 1'b0;
    tick;
    n_chk++;
    if ({bus.WinA, bus.WinB, bus.Tie, bus.Busy} !== 4'b0000) begin
      n_fail++; $display("FAIL last idle_flags: got %b want 0000", {bus.WinA, bus.WinB, bus.Tie, bus.Busy});
    end
  endtask

  task automatic test_full_game;
    exp_t       e;
    bit         ok;
    logic [3:0] tg [4];
    logic [3:0] av [4];
    logic [3:0] bv [4];
    tg = '{4'd1, 4'd2, 4'd3, 4'd4};
    av = '{4'd1, 4'd2, 4'd0, 4'd4};
    bv = '{4'd0, 4'd2, 4'd3, 4'd9};
    bus.Stop = 1'b1;
    tick;
    bus.Stop = 1'b0;
    n_chk++;
    if (bus.Busy !== 1'b0) begin n_fail++; $display("FAIL full stop_in_idle: got busy %b want 0", bus.Busy); end
    mdl_reset;
    bus.Start = 1'b1;
    tick;
    for (int r = 0; r < 4; r++) begin
      run_round(tg[r], 1'b1, av[r], 0, 1'b1, bv[r], 0);
      wait_done(ok);
      e = sbq.pop_front();
      n_chk++;
      if (!ok || {bus.ScoreA, bus.ScoreB, bus.Round} !== {e.a, e.b, e.r}) begin
        n_fail++; $display("FAIL full r%0d score: got %h want %h", r, {bus.ScoreA, bus.ScoreB, bus.Round}, {e.a, e.b, e.r});
      end
    end
    tick; tick; tick;
    n_chk++;
    if ({bus.WinA, bus.WinB, bus.Tie, bus.Busy} !== {mA > mB, mB > mA, mA == mB, 1'b0}) begin
      n_fail++; $display("FAIL full decision: got %b want %b", {bus.WinA, bus.WinB, bus.Tie, bus.Busy}, {mA > mB, mB > mA, mA == mB, 1'b0});
    end
    bus.Start = 1'b0;
    tick;
    n_chk++;
    if (bus.WinA !== 1'b0) begin n_fail++; $display("FAIL full wina_clear: got %b want 0", bus.WinA); end
  endtask

  task automatic test_stop;
    exp_t e;
    bit   ok;
    mdl_reset;
    bus.Start = 1'b1;
    tick;
    run_round(4'd9, 1'b1, 4'd9, 0, 1'b1, 4'd9, 0);
    wait_done(ok);
    e = sbq.pop_front();
    n_chk++;
    if (!ok || {bus.ScoreA, bus.ScoreB, bus.Round} !== {e.a, e.b, e.r}) begin
      n_fail++; $display("FAIL stop r1: got %h want %h", {bus.ScoreA, bus.ScoreB, bus.Round}, {e.a, e.b, e.r});
    end
    bus.RngVal = 4'd4; bus.RngVld = 1'b1;
    tick;
    bus.RngVld = 1'b0;
    bus.Stop = 1'b1; bus.PAVal = 4'd4; bus.PAVld = 1'b1;
    tick;
    bus.Stop = 1'b0; bus.PAVld = 1'b0;
    n_chk++;
    if ({bus.ScoreA, bus.ScoreB, bus.Round, bus.Tie, bus.WinA, bus.WinB, bus.Busy, bus.RoundDone} !==
        {mA[3:0], mB[3:0], 4'd1, 5'b10000}) begin
      n_fail++; $display("FAIL stop discard: got %h want %h", {bus.ScoreA, bus.ScoreB, bus.Round, bus.Tie, bus.WinA, bus.WinB, bus.Busy, bus.RoundDone}, {mA[3:0], mB[3:0], 4'd1, 5'b10000});
    end
    tick;
    n_chk++;
    if ({bus.RoundDone, bus.Tie, bus.Round} !== {1'b0, 1'b1, 4'd1}) begin
      n_fail++; $display("FAIL stop hold: got %h want %h", {bus.RoundDone, bus.Tie, bus.Round}, {1'b0, 1'b1, 4'd1});
    end
    bus.Start = 1'b0;
    tick;
  endtask

  task automatic test_first_bonus;
    exp_t e;
    bit   ok;
    mdl_reset;
    bus.Start = 1'b1;
    tick;
    run_round(4'd6, 1'b1, 4'd6, 0, 1'b1, 4'd6, 1);
    wait_done(ok);
    e = sbq.pop_front();
    n_chk++;
    if (!ok || {bus.ScoreA, bus.ScoreB, bus.Round} !== {e.a, e.b, e.r}) begin
      n_fail++; $display("FAIL bonus score: got %h want %h", {bus.ScoreA, bus.ScoreB, bus.Round}, {e.a, e.b, e.r});
    end
  endtask

  task automatic test_reset;
    exp_t e;
    bit   ok, seen_done;
    run_round(4'd5, 1'b1, 4'd5, 0, 1'b0, 4'd0, 0);
    wait_done(ok);
    e = sbq.pop_front();
    n_chk++;
    if (!ok || {bus.ScoreA, bus.ScoreB, bus.Round} !== {e.a, e.b, e.r}) begin
      n_fail++; $display("FAIL reset pre_round: got %h want %h", {bus.ScoreA, bus.ScoreB, bus.Round}, {e.a, e.b, e.r});
    end
    bus.RngVal = 4'd8; bus.RngVld = 1'b1;
    tick;
    bus.RngVld = 1'b0;
    tick;
    n_chk++;
    if ({bus.Busy, bus.ScoreA} !== {1'b1, mA[3:0]}) begin
      n_fail++; $display("FAIL reset mid_guess: got %h want %h", {bus.Busy, bus.ScoreA}, {1'b1, mA[3:0]});
    end
    bus.Start = 1'b0;
    Rst = 1'b0;
    seen_done = 1'b0;
    tick; if (bus.RoundDone === 1'b1) seen_done = 1'b1;
    tick; if (bus.RoundDone === 1'b1) seen_done = 1'b1;
    Rst = 1'b1;
    n_chk++;
    if ({bus.ScoreA, bus.ScoreB, bus.Round, bus.TimeLeft, bus.RoundDone, bus.Busy,
         bus.WinA, bus.WinB, bus.Tie} !== 25'd0) begin
      n_fail++; $display("FAIL reset outputs: got %h want 0", {bus.ScoreA, bus.ScoreB, bus.Round,
               bus.TimeLeft, bus.RoundDone, bus.Busy, bus.WinA, bus.WinB, bus.Tie});
    end
    tick; if (bus.RoundDone === 1'b1) seen_done = 1'b1;
    n_chk++;
    if (seen_done || bus.Busy !== 1'b0) begin
      n_fail++; $display("FAIL reset no_pulse: got done %b busy %b want 0 0", seen_done, bus.Busy);
    end
  endtask

  initial begin
    n_chk = 0; n_fail = 0;
    test_power_on;
    test_basic;
    test_timeout;
    test_duplicate;
    test_last_cycle;
    test_full_game;
    test_stop;
    test_first_bonus;
    test_reset;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog");
  end

endmodule
